// File: rtl/uart_rx_fifo.sv
// UART receiver with a 2-flop rxd synchronizer, 16x oversampling and a 4-entry receive FIFO.
// Ports: clk, rst (sync, high), rxd, baudrate, control, read_rx -> rx_valid, rxdata, status.
module uart_rx_fifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic [15:0] baudrate,
    input  logic [7:0]  control,
    input  logic        read_rx,
    output logic        rx_valid,
    output logic [7:0]  rxdata,
    output logic [7:0]  status
);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2
    } state_t;

    state_t state, state_n;

    logic        rxd_s1, rxd_s2, rxd_q;
    logic [15:0] div_cnt;
    logic [3:0]  tick_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        par_en, par_odd, two_stop;
    logic        fe_acc, pe_acc;
    logic        push_req;

    logic [9:0]  mem [0:3];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        overrun;

    logic        fall, tick, sample;
    logic        busy, go_start, shift_en, par_smp, stop_smp, push_set;
    logic        pop, full, wr_ok;
    logic [9:0]  head;
    logic        unused_ctl;

    assign unused_ctl = ^control[7:4];

    // rxd_q holds the previous synchronized level, so a start can only be
    // seen after the line has been high at least once (no restart on a
    // line held low after a framing error).
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_q  <= 1'b1;
        end else begin
            rxd_s1 <= rxd;
            rxd_s2 <= rxd_s1;
            rxd_q  <= rxd_s2;
        end
    end

    assign fall   = rxd_q & ~rxd_s2;
    assign tick   = (div_cnt == 16'd0);
    assign sample = tick && (tick_cnt == 4'd7);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   if (fall && control[3]) state_n = START;
            START:  if (sample) state_n = rxd_s2 ? IDLE : DATA;
            DATA:   if (sample && bit_cnt == 3'd7)
                        state_n = par_en ? PARITY : STOP1;
            PARITY: if (sample) state_n = STOP1;
            STOP1:  if (sample) state_n = two_stop ? STOP2 : IDLE;
            STOP2:  if (sample) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // output / control decode
    always_comb begin
        busy     = (state != IDLE);
        go_start = (state == IDLE) && fall && control[3];
        shift_en = (state == DATA) && sample;
        par_smp  = (state == PARITY) && sample;
        stop_smp = ((state == STOP1) || (state == STOP2)) && sample;
        push_set = sample && (((state == STOP1) && !two_stop) ||
                              (state == STOP2));
    end

    // oversample divider and bit datapath; a start edge realigns the
    // tick phase so tick 7 lands mid-bit
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= 16'd0;
            tick_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
            shift    <= 8'd0;
            par_en   <= 1'b0;
            par_odd  <= 1'b0;
            two_stop <= 1'b0;
            fe_acc   <= 1'b0;
            pe_acc   <= 1'b0;
            push_req <= 1'b0;
        end else begin
            push_req <= push_set;
            if (go_start) begin
                div_cnt  <= baudrate;
                tick_cnt <= 4'd0;
                bit_cnt  <= 3'd0;
                par_en   <= control[0];
                par_odd  <= control[1];
                two_stop <= control[2];
                fe_acc   <= 1'b0;
                pe_acc   <= 1'b0;
            end else if (tick) begin
                div_cnt  <= baudrate;
                tick_cnt <= tick_cnt + 4'd1;
            end else begin
                div_cnt  <= div_cnt - 16'd1;
            end
            if (shift_en) begin
                shift   <= {rxd_s2, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (par_smp)
                pe_acc <= ((^shift) ^ rxd_s2) != par_odd;
            if (stop_smp && !rxd_s2)
                fe_acc <= 1'b1;
        end
    end

    // FIFO: pop is evaluated first, so a full FIFO still accepts a push
    // in the same cycle as a read
    assign pop   = read_rx && (count != 3'd0);
    assign full  = (count == 3'd4);
    assign wr_ok = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= {fe_acc, pe_acc, shift};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            count   <= 3'd0;
            overrun <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 2'd1;
            if (pop)   rd_ptr <= rd_ptr + 2'd1;
            if (wr_ok && !pop)
                count <= count + 3'd1;
            else if (pop && !wr_ok)
                count <= count - 3'd1;
            if (pop)
                overrun <= 1'b0;
            else if (push_req && full)
                overrun <= 1'b1;
        end
    end

    assign head     = mem[rd_ptr];
    assign rx_valid = (count != 3'd0);
    assign rxdata   = rx_valid ? head[7:0] : 8'h00;
    assign status   = {count, overrun, rx_valid & head[9],
                       rx_valid & head[8], busy, rx_valid};

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo.
// Frames are modelled as they are sent; entries are checked as they are read.
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [15:0] baudrate = 16'd0;
    logic [7:0]  control = 8'h08;
    logic        read_rx = 1'b0;
    logic        rx_valid;
    logic [7:0]  rxdata;
    logic [7:0]  status;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] sb_q[$];
    bit model_ovr = 0;

    uart_rx_fifo dut (
        .clk(clk), .rst(rst), .rxd(rxd), .baudrate(baudrate),
        .control(control), .read_rx(read_rx),
        .rx_valid(rx_valid), .rxdata(rxdata), .status(status)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (16 * (int'(baudrate) + 1)) step();
    endtask

    task automatic send(input logic [7:0] d, input logic par_en,
                        input logic par_bit, input logic stop_bit);
        logic pe;
        pe = par_en ? (((^d) ^ par_bit) != control[1]) : 1'b0;
        if (sb_q.size() < 4) sb_q.push_back({~stop_bit, pe, d});
        else model_ovr = 1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (par_en) drive_bit(par_bit);
        drive_bit(stop_bit);
        if (stop_bit) drive_bit(1'b1);
    endtask

    task automatic pop_check(input string tag);
        logic [9:0] e;
        int n;
        n = 0;
        while (!rx_valid && n < 400) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, rx_valid, 1'b1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_data"}, rxdata, e[7:0]);
            chk({tag, "_fe"}, status[3], e[9]);
            chk({tag, "_pe"}, status[2], e[8]);
        end
        read_rx = 1'b1;
        step();
        read_rx = 1'b0;
        model_ovr = 0;
    endtask

    initial begin
        bit seen;
        int n;
        repeat (3) step();
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_data", rxdata, 8'h00);
        chk("rst_status", status, 8'h00);
        rst = 1'b0;
        repeat (20) step();

        // basic 8N1
        send(8'hA5, 0, 0, 1);
        chk("a5_status", status, 8'h21);
        chk("a5_data", rxdata, 8'hA5);
        pop_check("a5");
        chk("empty_status", status, 8'h00);

        // read on empty FIFO is ignored
        read_rx = 1'b1;
        step();
        read_rx = 1'b0;
        chk("empty_read", status, 8'h00);

        // odd parity
        control = 8'h0B;
        send(8'h03, 1, 0, 1);
        send(8'h03, 1, 1, 1);
        chk("par_count", status[7:5], 3'd2);
        pop_check("par0");
        pop_check("par1");

        // slower baud, even parity
        baudrate = 16'd1;
        control = 8'h09;
        send(8'h5A, 1, 0, 1);
        pop_check("baud1");
        baudrate = 16'd0;
        control = 8'h08;

        // 5-clk glitch is a false start
        seen = 0;
        rxd = 1'b0;
        repeat (5) begin step(); seen |= status[1]; end
        rxd = 1'b1;
        n = 0;
        while ((status[1] || n < 2) && n < 16) begin
            step();
            seen |= status[1];
            n++;
        end
        chk("glitch_seen_busy", seen, 1'b1);
        chk("glitch_idle", status[1], 1'b0);
        chk("glitch_nopush", rx_valid, 1'b0);

        // overrun
        for (int i = 0; i < 5; i++) send(8'h11 + 8'(i), 0, 0, 1);
        chk("ovr_count", status[7:5], 3'd4);
        chk("ovr_flag", status[4], model_ovr);
        pop_check("ovr_h11");
        chk("ovr_after_data", rxdata, sb_q[0][7:0]);
        chk("ovr_cleared", status[4], 1'b0);
        while (sb_q.size() > 0) pop_check("ovr_drain");
        chk("ovr_empty", status, 8'h00);

        // framing error, then line held low
        send(8'h7E, 0, 0, 0);
        repeat (48) step();
        chk("fe_no_restart", status[1], 1'b0);
        chk("fe_count", status[7:5], 3'd1);
        drive_bit(1'b1);
        send(8'h55, 0, 0, 1);
        pop_check("fe_7e");
        pop_check("fe_55");

        // reset mid-DATA of C3
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rxd = 1'b0;
        repeat (8) step();
        rst = 1'b1;
        step();
        rxd = 1'b1;
        step();
        chk("midrst_status", status, 8'h00);
        rst = 1'b0;
        repeat (20) step();
        send(8'h3C, 0, 0, 1);
        chk("midrst_count", status[7:5], 3'd1);
        pop_check("midrst_3c");
        chk("final_empty", status, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all logic.
REQ-002 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port rxd  input  1  serial line, idle high, asynchronous to clk.
REQ-004 SHALL have port baudrate  input  16  oversample divisor; sample tick every baudrate+1 clk cycles.
REQ-005 SHALL have port control  input  8  bit0 parity enable, bit1 odd parity (0=even), bit2 two stop bits, bit3 receiver enable, bits7:4 ignored.
REQ-006 SHALL have port read_rx  input  1  pop head entry; honoured only when rx_valid=1.
REQ-007 SHALL have port rx_valid  output  1  FIFO non-empty.
REQ-008 SHALL have port rxdata  output  8  head entry data byte.
REQ-009 SHALL have port status  output  8  {count[2:0], overrun, frame_err, parity_err, busy, rx_valid}.

Function
REQ-010 SHALL pass rxd through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-011 SHALL generate the sample tick from a 16-bit down-counter reloaded with baudrate; baudrate=0 gives a tick every clk.
REQ-012 SHALL use 16 ticks per bit; a 4-bit tick counter, sampling at tick index 7 of each bit.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-014 IDLE -> START on synchronized falling edge (1->0) with control[3]=1; tick divider and tick counter restart at the edge.
REQ-015 START: at tick 7, rxd=0 -> DATA; rxd=1 -> IDLE (false start, nothing stored).
REQ-016 DATA: 8 bits, LSB first, one per 16 ticks; after bit 7 -> PARITY if control[0]=1, else STOP1.
REQ-017 PARITY: parity_err = (XOR of 8 data bits XOR sampled bit) != control[1]; -> STOP1.
REQ-018 STOP1: rxd=0 at sample sets frame_err for this byte; -> STOP2 if control[2]=1, else push and -> IDLE.
REQ-019 STOP2: second stop bit checked likewise; push; -> IDLE.
REQ-020 Push SHALL occur on the clk after the final stop-bit sample; rx_valid rises one cycle later (latency 1 from sample).
REQ-021 After a frame error, receiver SHALL return to IDLE and require rxd=1 before detecting a new start (no restart on held-low line).
REQ-022 control sampled continuously; changes mid-frame take effect at the next IDLE->START transition only (latched at start).
REQ-023 FIFO: 4 entries of {frame_err, parity_err, data[7:0]}; 3-bit count 0..4; 2-bit read/write pointers wrapping 3->0.
REQ-024 rxdata, status.frame_err, status.parity_err SHALL reflect the head entry; all 0 when empty.
REQ-025 read_rx with rx_valid=0 SHALL be ignored (no pointer or count change).
REQ-026 Push into a full FIFO SHALL discard the new byte and set sticky overrun.
REQ-027 Simultaneous push and pop when full SHALL pop first, then accept the push; count stays 4, no overrun.
REQ-028 Simultaneous push and pop when empty is impossible to pop; push only, count 0->1.
REQ-029 overrun SHALL clear on the cycle after any accepted pop.
REQ-030 busy=1 whenever state != IDLE.
REQ-031 control[3]=0 mid-frame SHALL not abort the current frame; IDLE blocks new starts.

Reset
REQ-032 rst=1 SHALL force state IDLE, counters 0, FIFO pointers/count 0, overrun 0, synchronizer flops 1.
REQ-033 Outputs during/after reset: rx_valid=0, rxdata=8'h00, status=8'h00.
REQ-034 rst mid-frame SHALL abandon the frame with no push.

Verification
REQ-035 baudrate=0, control=8'h08, send 8'hA5 8N1 (16 clk/bit) -> rx_valid=1, rxdata=8'hA5, status=8'h21 (count 1).
REQ-036 control=8'h0B (odd parity), send 8'h03 with parity bit 0 -> entry stored, parity_err=1; with parity bit 1 -> parity_err=0.
REQ-037 0-low pulse of 5 clks on idle line, baudrate=0 -> no push, busy returns 0 within 8 clks.
REQ-038 Send 8'h11..8'h15 without reads -> count 4, overrun=1, entries 11..14; one read_rx -> rxdata=8'h12, overrun=0.
REQ-039 Stop bit driven 0 on 8'h7E -> entry 8'h7E with frame_err=1; next start ignored until rxd returns high.
REQ-040 rst asserted mid-DATA of 8'hC3, released, then 8'h3C sent -> only 8'h3C received, count 1.
